// File: rtl/bcd2binary_pkg.sv
// Shared constants and types for the packed-BCD to binary converter.
// WORDSIZE is the CPU datapath width the converter result feeds.
package bcd2binary_pkg;

  localparam int WORDSIZE = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] CORR_TH   = 4'd8;
  localparam logic [3:0] CORR_SUB  = 4'd3;

endpackage

// File: rtl/bcd2binary_if.sv
// Operand/result handshake bundle of the BCD to binary converter.
// The producer/consumer side uses master, the converter uses slave.
interface bcd2binary_if
  import bcd2binary_pkg::*;
#(
  parameter int NDIG  = 6,
  parameter int OUT_W = WORDSIZE
);

  logic                in_valid;
  logic                in_ready;
  logic [4*NDIG-1:0]   bcd_in;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    bin_out;
  logic                err;
  logic                ovf;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err, ovf
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err, ovf
  );

endinterface

// File: rtl/bcd2binary_sub3.sv
// One-digit correction cell of the reverse double-dabble: a shifted-in half
// of ten arrives as 8, so digits at or above 8 are pulled back by 3.
module bcd2binary_sub3
  import bcd2binary_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y
);

  assign y = (x >= CORR_TH) ? (x - CORR_SUB) : x;

endmodule

// File: rtl/bcd2binary.sv
// Iterative packed-BCD to binary converter: one right shift of {bcd_r, bin_r}
// plus per-digit correction per cycle, 4*NDIG cycles per operand.
module bcd2binary
  import bcd2binary_pkg::*;
#(
  parameter int NDIG  = 6,
  parameter int OUT_W = WORDSIZE
)(
  input  logic         clk,
  input  logic         rst_n,
  bcd2binary_if.slave  bus
);

  localparam int BW    = 4 * NDIG;
  localparam int CNT_W = $clog2(BW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BW - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [BW-1:0]      bcd_r, bin_r;
  logic [2*BW-1:0]    sh_full;
  logic [BW-1:0]      bcd_sh, bin_sh, bcd_fix;
  logic [OUT_W-1:0]   bin_fit, bin_q;
  logic               wide, err_q, ovf_q;
  logic               accept, drain, last, bad;

  function automatic logic has_bad_digit(input logic [BW-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (v[4*i +: 4] > DIGIT_MAX) b = 1'b1;
    return b;
  endfunction

  assign accept = bus.in_valid && (state == IDLE);
  assign drain  = bus.out_ready && (state == DONE);
  assign last   = (count == LAST);
  assign bad    = has_bad_digit(bus.bcd_in);

  assign sh_full = {bcd_r, bin_r} >> 1;
  assign bcd_sh  = sh_full[2*BW-1:BW];
  assign bin_sh  = sh_full[BW-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd2binary_sub3 u_sub3 (
      .x (bcd_sh[4*g +: 4]),
      .y (bcd_fix[4*g +: 4])
    );
  end

  // Result is taken from the final shift so it can be registered on the DONE edge.
  if (OUT_W >= BW) begin : g_fit_all
    assign bin_fit = OUT_W'(bin_sh);
    assign wide    = 1'b0;
  end else begin : g_fit_trunc
    assign bin_fit = bin_sh[OUT_W-1:0];
    assign wide    = |bin_sh[BW-1:OUT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad ? DONE : CONV;
      CONV:    if (last)   state_nxt = DONE;
      DONE:    if (drain)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      bin_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      count <= '0;
      if (bad) begin
        bin_q <= '0;
        err_q <= 1'b1;
        ovf_q <= 1'b0;
      end
    end else if (state == CONV) begin
      count <= count + 1'b1;
      if (last) begin
        bin_q <= bin_fit;
        err_q <= 1'b0;
        ovf_q <= wide;
      end
    end
  end

  // Shift register content is only meaningful during CONV, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      bcd_r <= bus.bcd_in;
      bin_r <= '0;
    end else if (state == CONV) begin
      bcd_r <= bcd_fix;
      bin_r <= bin_sh;
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_bcd2binary.sv
// Bench for bcd2binary: a 20-bit and an 8-bit instance share one stimulus
// stream; directed table, random operands vs. a decimal model, reset abort.
module tb_bcd2binary;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd2binary_if #(.NDIG(6), .OUT_W(20)) a ();
  bcd2binary_if #(.NDIG(6), .OUT_W(8))  b ();

  assign b.in_valid  = a.in_valid;
  assign b.bcd_in    = a.bcd_in;
  assign b.out_ready = a.out_ready;

  bcd2binary #(.NDIG(6), .OUT_W(20)) dut   (.clk(clk), .rst_n(rst_n), .bus(a));
  bcd2binary #(.NDIG(6), .OUT_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] bcd;
    logic [19:0] bin;
    logic        err;
    logic        ovf;
    logic [7:0]  bin8;
    logic        ovf8;
    int          lat;
    int          bp;
    bit          early;
    bit          spam;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal value of the digits, then reduced to each output width.
  task automatic model(input logic [23:0] bcd, output logic [19:0] bin20, output logic e,
                       output logic o20, output logic [7:0] bin8, output logic o8);
    longint v;
    int     d;
    v = 0;
    e = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    if (e) begin
      bin20 = '0; o20 = 1'b0; bin8 = '0; o8 = 1'b0;
    end else begin
      bin20 = 20'(v % (64'd1 << 20));
      o20   = (v >= (64'd1 << 20));
      bin8  = 8'(v % 256);
      o8    = (v >= 256);
    end
  endtask

  task automatic run_op(input logic [23:0] bcd, input logic [19:0] e_bin, input logic e_err,
                        input logic e_ovf, input logic [7:0] e_bin8, input logic e_ovf8,
                        input int e_lat, input int bp, input bit early, input bit spam);
    int          n;
    logic [19:0] hb;
    logic        stable;
    n = 0;
    while (!a.in_ready && n < 200) begin step(); n++; end
    chk("in_ready_idle", a.in_ready, 1);
    a.in_valid  = 1'b1;
    a.bcd_in    = bcd;
    a.out_ready = early;
    step();
    if (spam) a.bcd_in = 24'h987654;
    else      a.in_valid = 1'b0;
    chk("in_ready_busy", a.in_ready, 0);
    n = 0;
    while (!a.out_valid && n < 100) begin step(); n++; end
    chk("latency", n, e_lat);
    chk("out_valid8", b.out_valid, 1);
    chk("bin_out", a.bin_out, e_bin);
    chk("err", a.err, e_err);
    chk("ovf", a.ovf, e_ovf);
    chk("bin_out8", b.bin_out, e_bin8);
    chk("err8", b.err, e_err);
    chk("ovf8", b.ovf, e_ovf8);
    if (bp > 0) begin
      hb = a.bin_out;
      stable = 1'b1;
      for (int i = 0; i < bp; i++) begin
        step();
        if (a.out_valid !== 1'b1 || a.bin_out !== hb || a.err !== e_err || a.in_ready !== 1'b0)
          stable = 1'b0;
      end
      chk("bp_stable", stable, 1);
    end
    a.in_valid  = 1'b0;
    a.out_ready = 1'b1;
    step();
    chk("drained", {a.out_valid, a.in_ready}, 2'b01);
    step();
    chk("one_transfer", {a.out_valid, b.out_valid, a.in_ready}, 3'b001);
    a.out_ready = 1'b0;
  endtask

  initial begin
    logic [23:0] rb;
    logic [19:0] m_bin;
    logic [7:0]  m_bin8;
    logic        m_err, m_ovf, m_ovf8;
    logic        seen;
    bit          early;
    checks = 0;
    errors = 0;

    vecs[0] = '{24'h000255, 20'h000FF, 1'b0, 1'b0, 8'hFF, 1'b0, 24, 0,  1'b1, 1'b0};
    vecs[1] = '{24'h999999, 20'hF423F, 1'b0, 1'b0, 8'h3F, 1'b1, 24, 0,  1'b0, 1'b1};
    vecs[2] = '{24'h000000, 20'h00000, 1'b0, 1'b0, 8'h00, 1'b0, 24, 0,  1'b0, 1'b0};
    vecs[3] = '{24'h00A123, 20'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 0,  0,  1'b0, 1'b0};
    vecs[4] = '{24'h000256, 20'h00100, 1'b0, 1'b0, 8'h00, 1'b1, 24, 0,  1'b0, 1'b0};
    vecs[5] = '{24'h123456, 20'h1E240, 1'b0, 1'b0, 8'h40, 1'b1, 24, 10, 1'b0, 1'b1};
    vecs[6] = '{24'h0000F0, 20'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 0,  3,  1'b0, 1'b0};
    vecs[7] = '{24'h000042, 20'h0002A, 1'b0, 1'b0, 8'h2A, 1'b0, 24, 0,  1'b1, 1'b0};

    rst_n       = 1'b0;
    a.in_valid  = 1'b0;
    a.bcd_in    = '0;
    a.out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", a.in_ready, 1);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_outs", {a.bin_out, a.err, a.ovf}, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].ovf, vecs[i].bin8, vecs[i].ovf8,
             vecs[i].lat, vecs[i].bp, vecs[i].early, vecs[i].spam);

    // Reset in the middle of a conversion must abort it with no result.
    a.in_valid = 1'b1;
    a.bcd_in   = 24'h999999;
    step();
    a.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", a.in_ready, 1);
    chk("abort_out_valid", {a.out_valid, b.out_valid}, 0);
    chk("abort_outs", {a.bin_out, a.err, a.ovf}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (a.out_valid || b.out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    run_op(24'h000042, 20'h0002A, 1'b0, 1'b0, 8'h2A, 1'b0, 24, 0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      for (int d = 0; d < 6; d++)
        rb[4*d +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      model(rb, m_bin, m_err, m_ovf, m_bin8, m_ovf8);
      early = bit'($urandom_range(0, 1));
      run_op(rb, m_bin, m_err, m_ovf, m_bin8, m_ovf8, m_err ? 0 : 24,
             early ? 0 : int'($urandom_range(0, 3)), early, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
